// File: rtl/counter_mod.sv
// Modulo-(LIMIT+1) up/down counter with clear, load, combinational terminal
// count for zero-latency cascading, and a registered wrap pulse.
module counter_mod #(
  parameter int WIDTH   = 4,
  parameter int RST_VAL = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIN,
  input  logic [WIDTH-1:0] LIMIT,
  input  logic             UP,
  output logic [WIDTH-1:0] Dout,
  output logic             TC,
  output logic             WRAP
);

  localparam logic [WIDTH-1:0] RESET_VALUE = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             atTerminal;

  // An up-count wraps from anything at or above LIMIT, so loaded values
  // beyond the range fold back to zero; a down-count only wraps from zero.
  assign atTerminal = UP ? (count_q >= LIMIT) : (count_q == '0);

  assign TC = EN & ~CLR & ~LOAD & atTerminal;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (CLR) begin
      count_d = '0;
    end else if (LOAD) begin
      count_d = DIN;
    end else if (EN) begin
      if (atTerminal) begin
        count_d = UP ? '0 : LIMIT;
        wrap_d  = 1'b1;
      end else begin
        count_d = UP ? (count_q + ONE) : (count_q - ONE);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_q <= RESET_VALUE;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Dout = count_q;
  assign WRAP = wrap_q;

endmodule

// File: doc/counter_mod.md
COUNTER_MOD -- requirements
Module: counter_mod

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (legal range 2..16).
REQ-002 SHALL have parameter RST_VAL, default 0, value loaded into Dout on reset (must be < 2^WIDTH).
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low (RST=0 resets).
REQ-005 SHALL have port EN  input  1  count enable; one step per enabled cycle.
REQ-006 SHALL have port CLR  input  1  synchronous clear to 0.
REQ-007 SHALL have port LOAD  input  1  synchronous load of DIN.
REQ-008 SHALL have port DIN  input  WIDTH  load value.
REQ-009 SHALL have port LIMIT  input  WIDTH  terminal value; count range is 0..LIMIT inclusive.
REQ-010 SHALL have port UP  input  1  direction: 1 = increment, 0 = decrement.
REQ-011 SHALL have port Dout  output  WIDTH  current count, registered.
REQ-012 SHALL have port TC  output  1  terminal count, combinational: the next enabled step wraps.
REQ-013 SHALL have port WRAP  output  1  registered one-cycle pulse after a wrap step.

Function
REQ-014 SHALL apply per-edge priority CLR > LOAD > EN > hold.
REQ-015 SHALL set Dout=0, WRAP=0 on CLR=1, regardless of LOAD/EN/UP.
REQ-016 SHALL set Dout=DIN, WRAP=0 on LOAD=1 with CLR=0; DIN is loaded unchanged even if DIN > LIMIT.
REQ-017 SHALL, with EN=1 and UP=1: if Dout >= LIMIT, set Dout=0 and WRAP=1; else Dout=Dout+1, WRAP=0.
REQ-018 SHALL, with EN=1 and UP=0: if Dout == 0, set Dout=LIMIT and WRAP=1; else Dout=Dout-1, WRAP=0.
REQ-019 SHALL, on a down-count step with Dout > LIMIT (after a load), decrement normally with no clamping.
REQ-020 SHALL hold Dout and drive WRAP=0 when CLR=0, LOAD=0, EN=0.
REQ-021 SHALL drive TC = EN & ~CLR & ~LOAD & (UP ? (Dout >= LIMIT) : (Dout == 0)), with no register stage.
REQ-022 SHALL use TC so that chaining TC of stage n into EN of stage n+1 gives a correct multi-digit counter with zero added latency.
REQ-023 SHALL, with LIMIT=0, keep Dout=0 and assert WRAP on every cycle following an enabled step.
REQ-024 SHALL, with LIMIT=2^WIDTH-1, behave as a free-running binary counter with natural wrap.
REQ-025 SHALL sample LIMIT and UP each cycle; a change takes effect on the next edge with no pipeline.
REQ-026 SHALL perform all arithmetic modulo 2^WIDTH; there is no carry-out port other than TC/WRAP.
REQ-027 SHALL have a one-cycle latency from control inputs to Dout and WRAP.

Reset
REQ-028 SHALL, while RST=0, asynchronously force Dout=RST_VAL and WRAP=0, independent of CLK.
REQ-029 SHALL keep TC a function of current inputs and Dout during reset, so TC reflects Dout=RST_VAL.
REQ-030 SHALL resume on the first rising CLK edge after RST deasserts, with no extra idle cycle.
REQ-031 SHALL abandon any count in progress when reset asserts mid-operation; no partial state is retained.

Verification
REQ-032 Case 1: WIDTH=4, LIMIT=9, UP=1, EN=1 for 12 cycles from 0 -> Dout 1..9,0,1,2; TC high only while Dout=9; WRAP high the cycle Dout=0.
REQ-033 Case 2: LIMIT=9, UP=0, EN=1 from 0 -> Dout 9,8,7; TC high at Dout=0; WRAP high the cycle Dout=9.
REQ-034 Case 3: same edge CLR=1, LOAD=1, DIN=5, EN=1 -> Dout=0; next cycle LOAD=1 and EN=1 -> Dout=5, TC=0 during the load cycle.
REQ-035 Case 4: LOAD DIN=12 with LIMIT=9, then UP=1, EN=1 -> Dout=0, WRAP=1; a repeat with UP=0 -> Dout=11.
REQ-036 Case 5: two instances, LIMIT=9, first TC to second EN, 100 enabled cycles from 00 -> outputs 99 then 00; second instance WRAP pulses once.
REQ-037 Case 6: RST=0 mid-count between clock edges -> Dout=RST_VAL immediately; after release, counting resumes from RST_VAL on the first edge.
